// File: rtl/lsu_pkg.sv
// Shared encodings and the captured-request payload for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned HALF_W   = 16;
  localparam int unsigned ADDR_W   = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Only the low address bits and low store half are needed after acceptance.
  typedef struct packed {
    logic              we;
    lsu_size_e         size;
    logic              is_unsigned;
    logic [1:0]        addr_lo;
    logic [HALF_W-1:0] wdata_lo;
  } lsu_req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extract/extend for loads, lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  lsu_size_e       size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] store_data_c
);

  logic [4:0]        shamt;
  logic [HALF_W-1:0] shifted;
  logic [XLEN-1:0]   mask;
  logic [XLEN-1:0]   ins;

  always_comb begin
    shamt = {addr_lo, 3'b000};
    if (size == SZ_HALF) begin
      shamt = {addr_lo[1], 4'b0000};
    end
    shifted     = HALF_W'(word >> shamt);
    load_data_c = word;
    mask        = '1;
    ins         = wdata;
    case (size)
      SZ_BYTE: begin
        load_data_c = is_unsigned ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
        mask        = XLEN'(32'h0000_00FF << shamt);
        ins         = XLEN'({24'h0, wdata[7:0]} << shamt);
      end
      SZ_HALF: begin
        load_data_c = is_unsigned ? {16'h0, shifted}
                                  : {{16{shifted[15]}}, shifted};
        mask        = XLEN'(32'h0000_FFFF << shamt);
        ins         = XLEN'({16'h0, wdata[15:0]} << shamt);
      end
      default: ;
    endcase
    // Word case leaves mask all-ones, so the merge degenerates to wdata.
    store_data_c = (word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte/half/word CPU requests into word-aligned
// memory accesses, with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 2048
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_we,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH_WORDS) << 2;

  lsu_state_e        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

  lsu_size_e         size_in;
  logic              req_err_c;
  logic [XLEN-1:0]   load_data_c;
  logic [XLEN-1:0]   store_data_c;

  // mem_rdata is the addressed word during READ, which is when both uses occur.
  lsu_lane_align u_align (
    .addr_lo      (req_q.addr_lo),
    .size         (req_q.size),
    .is_unsigned  (req_q.is_unsigned),
    .word         (mem_rdata),
    .wdata        ({16'h0, req_q.wdata_lo}),
    .load_data_c  (load_data_c),
    .store_data_c (store_data_c)
  );

  always_comb begin
    size_in   = lsu_size_e'(req_size);
    req_err_c = (size_in == SZ_BAD)
             || ((size_in == SZ_HALF) && req_addr[0])
             || ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00))
             || ({1'b0, req_addr} >= ADDR_LIMIT);
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = '{we:          req_we,
                    size:        size_in,
                    is_unsigned: req_unsigned,
                    addr_lo:     req_addr[1:0],
                    wdata_lo:    req_wdata[HALF_W-1:0]};
          if (req_err_c) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_we && (size_in == SZ_WORD)) begin
              state_d     = ST_WRITE;
              mem_we_d    = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (req_q.we) begin
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = store_data_c;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_data_c;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  // Reset kills an in-flight write in the same cycle, so no store lands partially.
  assign mem_we     = mem_we_q & resetn;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table plus scoreboard, with a memory model.
module tb_load_store_unit;

  localparam int unsigned DEPTH = 2048;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Word memory: combinational read, write on the rising edge.
  logic [31:0] mem [DEPTH];
  logic        do_preload;

  always @(posedge clock) begin
    if (do_preload) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
      mem[4]       <= 32'h8899_AABB;
      mem[DEPTH-1] <= 32'h7F00_0000;
    end else if (mem_we && (mem_addr < 32'(4 * DEPTH))) begin
      mem[mem_addr[12:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_addr < 32'(4 * DEPTH)) ? mem[mem_addr[12:2]] : 32'h0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        reload;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we_cyc;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cyc;
    logic [31:0] wdata;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic preload();
    @(negedge clock);
    do_preload = 1'b1;
    @(posedge clock);
    #1 do_preload = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic reload, input int hold, input logic [31:0] er,
                              input logic ee, input int lat, input int wc,
                              input logic [31:0] ew);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.reload = reload; v.hold = hold; v.exp_rdata = er; v.exp_err = ee;
    v.exp_lat = lat; v.exp_we_cyc = wc; v.exp_wdata = ew;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input int idx);
    int          cyc;
    int          we_cnt;
    int          we_cyc;
    logic [31:0] we_data;
    bit          got;
    exp_t        e;
    string       tag;
    tag = $sformatf("v%0d", idx);
    if (v.reload) preload();
    @(negedge clock);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    resp_ready = (v.hold == 0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (req_ready) got = 1;
      else @(negedge clock);
    end
    if (!got) begin
      check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, v.exp_we_cyc, v.exp_wdata});
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    cyc = 1; we_cnt = 0; we_cyc = 0; we_data = 32'h0; got = 0;
    while (cyc <= 20) begin
      if (mem_we) begin we_cnt++; we_cyc = cyc; we_data = mem_wdata; end
      if (resp_valid) begin got = 1; break; end
      @(negedge clock);
      cyc++;
    end
    e = sb.pop_front();
    if (!got) begin
      check({tag, "_resp_timeout"}, 32'(resp_valid), 32'd1);
      resp_ready = 1'b1;
      return;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    check({tag, "_err"}, 32'(resp_err), 32'(e.err));
    check({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clock);
      if (mem_we) we_cnt++;
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, e.rdata);
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    if (mem_we) we_cnt++;
    check({tag, "_idle_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_idle_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_we_count"}, 32'(we_cnt), (e.we_cyc != 0) ? 32'd1 : 32'd0);
    if (e.we_cyc != 0) begin
      check({tag, "_we_cycle"}, 32'(we_cyc), 32'(e.we_cyc));
      check({tag, "_we_data"}, we_data, e.wdata);
    end
  endtask

  // Reset arriving mid sub-word store (READ when k=1, WRITE when k=2).
  task automatic reset_mid_store(input int k);
    string tag;
    tag = $sformatf("rst%0d", k);
    preload();
    @(negedge clock);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    for (int c = 1; c < k; c++) begin
      check({tag, "_pre_we"}, 32'(mem_we), 32'd0);
      @(negedge clock);
    end
    resetn = 1'b0;
    #1 check({tag, "_we_in_reset"}, 32'(mem_we), 32'd0);
    @(negedge clock);
    check({tag, "_we_after_edge"}, 32'(mem_we), 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_mem_word"}, mem[4], 32'h8899_AABB);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    do_preload = 1'b0;
    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;

    // we size uns addr wdata reload hold | rdata err lat we_cyc we_data
    vecs.push_back(mk(0, 0, 0, 32'h11,   32'h0,         1, 0, 32'hFFFF_FFAA, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h11,   32'h0,         0, 0, 32'h0000_00AA, 0, 2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h12,   32'h0000_1234, 0, 0, 32'h0,         0, 3, 2, 32'h1234_AABB));
    vecs.push_back(mk(0, 2, 0, 32'h10,   32'h0,         0, 0, 32'h1234_AABB, 0, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h10,   32'hFFFF_FF77, 1, 0, 32'h0,         0, 3, 2, 32'h8899_AA77));
    vecs.push_back(mk(1, 2, 0, 32'h14,   32'hDEAD_BEEF, 0, 0, 32'h0,         0, 2, 1, 32'hDEAD_BEEF));
    vecs.push_back(mk(0, 2, 0, 32'h10,   32'h0,         0, 0, 32'h8899_AA77, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'h14,   32'h0,         0, 0, 32'hDEAD_BEEF, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'h13,   32'h0,         0, 0, 32'h0,         1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h11,   32'h0,         0, 0, 32'h0,         1, 1, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'h2000, 32'h0,         0, 0, 32'h0,         1, 1, 0, 0));
    vecs.push_back(mk(0, 3, 0, 32'h10,   32'h0,         0, 0, 32'h0,         1, 1, 0, 0));
    vecs.push_back(mk(1, 2, 0, 32'h2000, 32'h1111_1111, 0, 0, 32'h0,         1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h12,   32'h0,         1, 0, 32'hFFFF_8899, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h10,   32'h0,         0, 0, 32'h0000_AABB, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h13,   32'h0,         0, 0, 32'hFFFF_FF88, 0, 2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h10,   32'h0000_CAFE, 0, 0, 32'h0,         0, 3, 2, 32'h8899_CAFE));
    vecs.push_back(mk(0, 0, 0, 32'h1FFF, 32'h0,         0, 0, 32'h0000_007F, 0, 2, 0, 0));
    vecs.push_back(mk(0, 2, 0, 32'h10,   32'h0,         1, 3, 32'h8899_AABB, 0, 2, 0, 0));

    do_preload = 1'b1;
    repeat (3) @(posedge clock);
    #1 do_preload = 1'b0;
    @(negedge clock);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'h0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    resetn = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i], i);

    reset_mid_store(1);
    reset_mid_store(2);
    run_txn(mk(0, 2, 0, 32'h10, 32'h0, 0, 0, 32'h8899_AABB, 0, 2, 0, 0), 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the CPU datapath and the word-organised data memory, which has a combinational read and a write on `posedge clock`. Converts CPU load/store requests of byte, halfword or word size into word-aligned memory accesses. Sub-word loads are lane-selected and sign- or zero-extended. Sub-word stores use a read-modify-write so bytes outside the target lanes are preserved. Requests and responses use valid/ready handshakes, and misaligned or out-of-range accesses return an error without touching memory.

## Interface
Parameters:
- `DEPTH_WORDS`, default 2048: memory depth in 32-bit words; legal byte addresses are 0 to 4*DEPTH_WORDS-1.

Ports:
- `clock`  in  1  single clock, all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal and flags an error.
- `req_unsigned`  in  1  loads only: zero-extend when 1.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned, out-of-range or illegal-size access.
- `mem_addr`  out  32  word-aligned address, {addr[31:2],2'b00}.
- `mem_wdata`  out  32  full word to write.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  32  combinational read data for `mem_addr`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: capture we, size, unsigned, addr and wdata; compute the error flag.
- Error condition: any of the following.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - size=3.
  - addr ≥ 4*DEPTH_WORDS.
- Transitions out of IDLE:
  - Error → RESP, with `resp_err`=1 and `resp_rdata`=0.
  - Load → READ.
  - Word store → WRITE.
  - Sub-word store → READ.
- READ:
  - Drive `mem_addr` and register `mem_rdata` into `word_q`.
  - Load → RESP.
  - Sub-word store → WRITE.
- WRITE:
  - `mem_we`=1 for exactly this one cycle.
  - Word store: `mem_wdata`=wdata.
  - Sub-word store: `mem_wdata`=`word_q` with the target lanes replaced.
    - Byte: lane addr[1:0] gets wdata[7:0].
    - Halfword: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - Next state: RESP.
- RESP:
  - `resp_valid`=1; hold all response outputs stable until `resp_ready`=1, then return to IDLE.
  - Load data: lane-select from `word_q`.
    - Byte lane addr[1:0]; halfword lane addr[1].
    - Extend to 32 bits, sign or zero per `req_unsigned`.
- `req_ready`=0 in every state except IDLE; only one transaction is outstanding.
- Reset:
  - While `resetn`=0, `mem_we` is forced to 0 combinationally, so there is no write in the reset cycle.
  - Next state is IDLE and the in-flight transaction is dropped.
  - A store is either fully written or not written; no partial write.

## Timing
- Reset values:
  - state IDLE; `req_ready`=1; `resp_valid`=0; `resp_err`=0; `resp_rdata`=0.
  - `mem_we`=0; `mem_addr`=0; `mem_wdata`=0.
- Latency, counting the accept edge as cycle 0, to the cycle `resp_valid` is first high:
  - Error: 1.
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
- Back-to-back: the next request is accepted no earlier than the cycle after the RESP handshake. Throughput is at most one transaction per 3 cycles for loads and word stores, and per 4 for sub-word stores.
- `mem_addr` is stable for all of READ and WRITE.
- `mem_rdata` is sampled only at the end of READ.
- Memory write takes effect at the edge ending WRITE, so a load issued immediately after a store observes the new data.

## Structure
- Package `lsu_pkg` holds:
  - Size encodings: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - State encodings.
- Sub-module `lsu_lane_align` (combinational):
  - Extract and extend for loads.
  - Lane merge for stores.
  - Inputs: addr[1:0], size, unsigned, word, wdata.
- The parent contains the FSM and the registers.

## Test plan
Memory word at 0x10 preloaded with 0x8899AABB for all scenarios.
- Load byte, signed, at 0x11 → `resp_rdata`=0xFFFFFFAA at cycle 2. Same with `req_unsigned`=1 → 0x000000AA. `mem_we` never high.
- Store halfword 0x00001234 at 0x12 → `mem_we` high exactly in cycle 2 with `mem_wdata`=0x1234AABB. A following load word at 0x10 returns 0x1234AABB.
- Store byte 0x77 at 0x10, then store word 0xDEADBEEF at 0x14 → word 0x10 becomes 0x8899AA77 and word 0x14 becomes 0xDEADBEEF; word latency 2, byte latency 3.
- Load word at 0x13, and load halfword at 0x11 → `resp_err`=1 at cycle 1, `resp_rdata`=0, no `mem_we`. Load word at 4*DEPTH_WORDS → `resp_err`=1.
- Load word at 0x10 with `resp_ready` held low 3 cycles → `resp_valid` and `resp_rdata`=0x8899AABB held stable, `req_ready`=0 throughout. IDLE is reached the cycle after `resp_ready`=1.
- Sub-word store to 0x10 with `resetn` low during READ → `mem_we` never asserts, word stays 0x8899AABB, and the unit is in IDLE with `req_ready`=1 after reset.
